// File: rtl/hazard_stall_controller_if.sv
// Pipeline <-> hazard/stall controller signal bundle.
//   master : pipeline side, drives ID/EX hazard info, receives stall/flush controls
//   slave  : controller side
// Signal names follow the pipeline's own naming so they line up with the datapath.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  // ID / EX hazard information
  logic [4:0]       IF_IDRegisterRs;
  logic [4:0]       IF_IDRegisterRt;
  logic             ID_EXMemRead;
  logic [4:0]       ID_EXRegisterRt;
  logic             ID_MdStart;
  logic             ID_MdReadHiLo;
  logic             EX_BranchTaken;
  // pipeline controls
  logic             PCWrite;
  logic             IF_IDWrite;
  logic             ID_EXBubble;
  logic             IF_IDFlush;
  logic             ID_EXFlush;
  // mult/div unit status
  logic             MdIssue;
  logic             MdBusy;
  logic             MdDone;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output IF_IDRegisterRs, IF_IDRegisterRt, ID_EXMemRead, ID_EXRegisterRt,
           ID_MdStart, ID_MdReadHiLo, EX_BranchTaken,
    input  PCWrite, IF_IDWrite, ID_EXBubble, IF_IDFlush, ID_EXFlush,
           MdIssue, MdBusy, MdDone, StallCount
  );

  modport slave (
    input  IF_IDRegisterRs, IF_IDRegisterRt, ID_EXMemRead, ID_EXRegisterRt,
           ID_MdStart, ID_MdReadHiLo, EX_BranchTaken,
    output PCWrite, IF_IDWrite, ID_EXBubble, IF_IDFlush, ID_EXFlush,
           MdIssue, MdBusy, MdDone, StallCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Covers load-use hazards, multi-cycle mult/div occupancy and taken-branch
// flushes; keeps a saturating stall-cycle counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard_stall_controller_if.slave (hazard inputs, pipeline controls,
//           mult/div status, StallCount)
// All pipeline controls are combinational in the current cycle; MdBusy, MdDone
// and StallCount are registered.
module hazard_stall_controller #(
  parameter int MD_LAT = 8,   // mult/div occupancy in cycles, 1..63
  parameter int CNT_W  = 16   // stall counter width
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hazard_stall_controller_if.slave    bus
);

  localparam logic [5:0] LP_MD_LAST = 6'(MD_LAT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} md_state_e;

  md_state_e        r_state, w_state_nxt;
  logic [5:0]       r_mdcnt, w_mdcnt_nxt;
  logic             r_done,  w_done_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic w_ld_haz, w_md_haz, w_stall, w_issue, w_busy;

  assign w_busy   = (r_state == S_RUN);
  assign w_ld_haz = bus.ID_EXMemRead && (bus.ID_EXRegisterRt != 5'd0) &&
                    ((bus.ID_EXRegisterRt == bus.IF_IDRegisterRs) ||
                     (bus.ID_EXRegisterRt == bus.IF_IDRegisterRt));
  assign w_md_haz = w_busy && (bus.ID_MdReadHiLo || bus.ID_MdStart);
  // A taken branch kills the ID instruction, so its hazards are moot.
  assign w_stall  = (w_ld_haz || w_md_haz) && !bus.EX_BranchTaken;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mdcnt <= 6'd0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mdcnt <= w_mdcnt_nxt;
      r_done  <= w_done_nxt;
      if (w_stall && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_mdcnt_nxt = r_mdcnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_RUN;
          w_mdcnt_nxt = LP_MD_LAST;
        end
      end
      S_RUN: begin
        // Branch flushes do not touch a running op; it always runs to completion.
        if (r_mdcnt != 6'd0) begin
          w_mdcnt_nxt = r_mdcnt - 6'd1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    bus.PCWrite     = 1'b1;
    bus.IF_IDWrite  = 1'b1;
    bus.ID_EXBubble = 1'b0;
    bus.IF_IDFlush  = 1'b0;
    bus.ID_EXFlush  = 1'b0;
    w_issue         = 1'b0;
    if (!rst_n) begin
      // Hold the front end frozen while in reset.
      bus.PCWrite     = 1'b0;
      bus.IF_IDWrite  = 1'b0;
      bus.ID_EXBubble = 1'b1;
    end else if (bus.EX_BranchTaken) begin
      bus.IF_IDFlush  = 1'b1;
      bus.ID_EXFlush  = 1'b1;
    end else if (w_stall) begin
      bus.PCWrite     = 1'b0;
      bus.IF_IDWrite  = 1'b0;
      bus.ID_EXBubble = 1'b1;
    end else begin
      // Only reachable with MdBusy=0 when ID_MdStart is set (else md_haz stalls).
      w_issue = bus.ID_MdStart;
    end
  end

  assign bus.MdIssue    = w_issue;
  assign bus.MdBusy     = w_busy;
  assign bus.MdDone     = r_done;
  assign bus.StallCount = r_cnt;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Sequences pipeline stalls and flushes for the 5-stage MIPS pipeline; works alongside the EX-stage forwarding logic.
- Handles three cases:
  - load-use hazards that forwarding cannot cover;
  - occupancy of a multi-cycle mult/div unit (HI/LO readers and a second mult/div wait for completion);
  - taken-branch flushes.
- Drives PC/IF_ID write enables, ID_EX bubble insertion and flushes, and keeps a saturating stall-cycle counter.

Parameters:
- MD_LAT, 8, mult/div occupancy in cycles (legal range 1..63).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IF_IDRegisterRs  input  5  rs of the instruction in ID.
- IF_IDRegisterRt  input  5  rt of the instruction in ID.
- ID_EXMemRead  input  1  instruction in EX is a load.
- ID_EXRegisterRt  input  5  load destination in EX.
- ID_MdStart  input  1  instruction in ID is mult/multu/div/divu.
- ID_MdReadHiLo  input  1  instruction in ID is mfhi/mflo.
- EX_BranchTaken  input  1  branch in EX resolved taken.
- PCWrite  output  1  PC update enable.
- IF_IDWrite  output  1  IF/ID register enable.
- ID_EXBubble  output  1  zero the control fields entering ID/EX.
- IF_IDFlush  output  1  clear IF/ID.
- ID_EXFlush  output  1  clear ID/EX.
- MdIssue  output  1  mult/div accepted this cycle (starts the unit).
- MdBusy  output  1  mult/div unit occupied (registered).
- MdDone  output  1  one-cycle completion pulse (registered).
- StallCount  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - mdcnt=0, MdBusy=0, MdDone=0, StallCount=0.
  - While reset is held: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1, flushes=0, MdIssue=0.
- Combinational hazard terms:
  - ld_haz = ID_EXMemRead & (ID_EXRegisterRt!=0) & (ID_EXRegisterRt==IF_IDRegisterRs | ID_EXRegisterRt==IF_IDRegisterRt).
  - md_haz = MdBusy & (ID_MdReadHiLo | ID_MdStart).
  - stall = (ld_haz | md_haz) & ~EX_BranchTaken.
- Priority (highest first):
  - EX_BranchTaken: IF_IDFlush=1, ID_EXFlush=1, PCWrite=1, IF_IDWrite=1, ID_EXBubble=0, MdIssue=0. The ID-stage instruction is killed, so no stall and no issue.
  - stall: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1, flushes=0, MdIssue=0.
  - Otherwise: PCWrite=1, IF_IDWrite=1, ID_EXBubble=0, flushes=0, MdIssue=ID_MdStart.
- All of the above outputs are same-cycle combinational. No added latency.
- Mult/div sequencer (two states, IDLE when MdBusy=0 and RUN when MdBusy=1):
  - IDLE + MdIssue: next edge sets MdBusy=1 and mdcnt=MD_LAT-1.
  - RUN, mdcnt!=0: mdcnt decrements.
  - RUN, mdcnt==0: next edge sets MdBusy=0 and MdDone=1 (one cycle only).
  - Result: MdBusy is high for exactly MD_LAT cycles starting the cycle after issue.
  - A mfhi/mflo in ID stalls while MdBusy=1. It proceeds in the MdDone cycle.
  - A second mult/div stalls likewise. It issues in the MdDone cycle, which sets MdBusy again on the next edge, so back-to-back operations have no idle gap beyond that.
  - Branch flushes do not cancel a running operation; the counter continues.
  - mdcnt width is 6 bits.
- StallCount:
  - Increments on every edge where stall=1.
  - Saturates at all-ones; no wrap.
  - Flush cycles are not counted.
- Load-use with simultaneous md_haz produces a single stall cycle per cycle; it is counted once.
- If reset deasserts mid-operation, the unit restarts in IDLE; the in-flight mult/div is lost.

Test Plan:
- Load then use: ID_EXMemRead=1, ID_EXRegisterRt=8, IF_IDRegisterRs=8 -> PCWrite=0, IF_IDWrite=0, ID_EXBubble=1 for that cycle; StallCount becomes 1.
- Load to $0: ID_EXRegisterRt=0, IF_IDRegisterRt=0 -> no stall; PCWrite=1.
- MD_LAT=8, ID_MdStart pulse, then ID_MdReadHiLo held:
  - MdIssue=1 for one cycle.
  - MdBusy high 8 cycles, with stall for all 8.
  - MdDone=1 on cycle 9 with PCWrite=1.
  - StallCount=8.
- Branch priority: ld_haz=1 and EX_BranchTaken=1 in the same cycle -> IF_IDFlush=ID_EXFlush=1, PCWrite=1, ID_EXBubble=0; StallCount unchanged.
- Back-to-back mult: second ID_MdStart held during busy -> stalls, then MdIssue=1 in the MdDone cycle, and MdBusy reasserts on the next cycle.
- Reset while MdBusy=1 with mdcnt=3 -> MdBusy=0, MdDone=0, StallCount=0 immediately with no clock edge; PCWrite=0 until release.
- Saturation: CNT_W=4, 20 stall cycles -> StallCount=15.
